ram_1w_nrs_cleared: RTL
=======================

// Module: ram_1w_nrs_cleared
// PURPOSE
//  Single-clock RAM: one byte-masked write port, READ_PORTS independent synchronous read ports.
//  Configurable read latency and a hardware clear engine that zeroes the whole array after reset or on request.
//  Backing store for VexiiRiscv multi-issue register-file shadows, BTB/tag tables and LSU tables.
//  Those tables need N reads per cycle and a known-zero initial state.
// PARAMETERS
//  WORD_COUNT    64   number of entries; any value >= 2
//  WORD_WIDTH    32   bits per entry
//  MASK_WIDTH    4    write-mask lanes; WORD_WIDTH % MASK_WIDTH == 0; lane width COL_W = WORD_WIDTH/MASK_WIDTH
//  READ_PORTS    2    number of read ports, >= 1
//  READ_LATENCY  1    cycles from rd_en to rd_data; legal values 1 or 2 (elaboration error otherwise)
//  Local: AW = max(1, $clog2(WORD_COUNT))
// PORTS
//  clk         in   1                    clock, all logic on rising edge
//  reset       in   1                    synchronous, active-high reset
//  wr_en       in   1                    write strobe
//  wr_mask     in   MASK_WIDTH           per-lane write enable
//  wr_addr     in   AW                   write address
//  wr_data     in   WORD_WIDTH           write data
//  rd_en       in   READ_PORTS           per-port read strobe
//  rd_addr     in   READ_PORTS*AW        port p at [p*AW +: AW]
//  rd_data     out  READ_PORTS*WORD_WIDTH  port p at [p*WORD_WIDTH +: WORD_WIDTH]
//  clear_req   in   1                    pulse: start a full clear
//  clear_busy  out  1                    high while the clear engine owns the array
// BEHAVIOUR
//  Reset values: rd_data=0, all pipeline regs=0, clear_busy=1, FSM=CLEAR, clear_ptr=0.
//  Clear FSM, states IDLE and CLEAR:
//   - CLEAR: each cycle write all-zero to entry clear_ptr and increment clear_ptr.
//   - CLEAR exit: at clear_ptr==WORD_COUNT-1 write that entry, go to IDLE next cycle.
//   - Clear duration: exactly WORD_COUNT cycles; clear_busy is registered (1 in CLEAR, 0 in IDLE).
//   - IDLE & clear_req=1: next cycle FSM=CLEAR, clear_ptr=0.
//   - clear_req during CLEAR is ignored, with no restart.
//   - reset mid-clear: restarts at clear_ptr=0.
//  Writes: while IDLE, wr_en=1 updates lane i of ram[wr_addr] iff wr_mask[i]; other lanes keep their value.
//   - wr_en during CLEAR is dropped silently; callers must gate on clear_busy.
//   - wr_addr >= WORD_COUNT: write dropped.
//  Reads: port p sampled at cycle t with rd_en[p]=1 and FSM=IDLE.
//   - Data appears on rd_data[p] at edge t+READ_LATENCY.
//   - rd_data[p] holds its last value when not read; no X on output.
//   - rd_en during CLEAR is ignored; rd_data holds its previous value.
//   - rd_addr >= WORD_COUNT: returns 0.
//   - READ_LATENCY=2: stage-2 reg loads from stage 1 only when stage 1 was loaded the previous cycle (enable pipelined).
//  Ports are fully independent; any number of ports may read the same address in the same cycle.
//  Simultaneous write and read of the same address, same cycle: see CONFIGURATION.
//  Simultaneous reset and clear_req: reset wins (same result, clear from 0).
// CONFIGURATION
//  Macro RAM_1W_NRS_CLEARED_BYPASS_EN:
//   - Defined: write-first forwarding. A read of wr_addr in the same cycle as an accepted write
//     returns wr_data on masked lanes and old content on unmasked lanes.
//   - Not defined: read-first. Same-cycle read returns the pre-write content.
//   - Other behaviour is identical in both builds; forwarding adds one mux per port in stage 1.
// TESTING
//  1 reset 1 cycle, idle -> clear_busy=1 for exactly WORD_COUNT cycles; then every address reads 0.
//  2 write 0xDEADBEEF mask 4'b1111 @5, then 0x000000AA mask 4'b0001 @5, read port0 @5
//    -> 0xDEADBEAA after READ_LATENCY cycles.
//  3 port0 reads @3 and port1 reads @7 in the same cycle, with preloaded 0x11/0x77
//    -> rd_data port0=0x11 and port1=0x77 simultaneously; both hold while rd_en=0.
//  4 with @9=0x12345678, write 0xCAFEF00D mask 4'b0011 @9 and read @9 in the same cycle
//    -> BYPASS_EN build: 0x1234F00D; default build: 0x12345678.
//  5 clear_req in IDLE, wr_en/rd_en asserted during CLEAR
//    -> writes dropped, rd_data unchanged; after clear_busy falls all entries 0.
//  6 reset asserted at clear_ptr=WORD_COUNT/2 -> clear restarts at 0 and lasts WORD_COUNT more cycles;
//    repeat the whole suite with READ_LATENCY=2.

Source files
------------

// File: rtl/ram_1w_nrs_cleared.sv
// Single-clock RAM: one lane-masked write port, READ_PORTS synchronous read ports, and a clear engine
// that zeroes the array after reset or on clear_req. Define RAM_1W_NRS_CLEARED_BYPASS_EN for write-first reads.
module ram_1w_nrs_cleared #(
    parameter int unsigned WORD_COUNT   = 64,
    parameter int unsigned WORD_WIDTH   = 32,
    parameter int unsigned MASK_WIDTH   = 4,
    parameter int unsigned READ_PORTS   = 2,
    parameter int unsigned READ_LATENCY = 1,
    localparam int unsigned AW = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr_en,
    input  logic [MASK_WIDTH-1:0]            wr_mask,
    input  logic [AW-1:0]                    wr_addr,
    input  logic [WORD_WIDTH-1:0]            wr_data,
    input  logic [READ_PORTS-1:0]            rd_en,
    input  logic [READ_PORTS*AW-1:0]         rd_addr,
    output logic [READ_PORTS*WORD_WIDTH-1:0] rd_data,
    input  logic                             clear_req,
    output logic                             clear_busy
);

    localparam int unsigned COL_W = WORD_WIDTH / MASK_WIDTH;
    localparam logic [AW:0]   WC_L     = (AW+1)'(WORD_COUNT);
    localparam logic [AW-1:0] LAST_PTR = AW'(WORD_COUNT - 1);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    if (WORD_WIDTH % MASK_WIDTH != 0) begin : g_bad_mask
        $error("WORD_WIDTH must be a multiple of MASK_WIDTH");
    end

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t          state;
    logic [AW-1:0]   clear_ptr;
    logic [WORD_WIDTH-1:0] mem [WORD_COUNT];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_CLEAR;
            clear_ptr  <= '0;
            clear_busy <= 1'b1;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (clear_ptr == LAST_PTR) begin
                        state      <= S_IDLE;
                        clear_ptr  <= '0;
                        clear_busy <= 1'b0;
                    end else begin
                        clear_ptr <= clear_ptr + 1'b1;
                    end
                end
                default: begin
                    if (clear_req) begin
                        state      <= S_CLEAR;
                        clear_ptr  <= '0;
                        clear_busy <= 1'b1;
                    end
                end
            endcase
        end
    end

    // The clear engine and the user write share one physical write port.
    logic                  idle;
    logic                  wr_accept;
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic [MASK_WIDTH-1:0] mem_lanes;

    always_comb begin
        idle      = !reset && (state == S_IDLE);
        wr_accept = idle && wr_en && ({1'b0, wr_addr} < WC_L);
        mem_we    = 1'b0;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        mem_lanes = wr_mask;
        if (!reset && state == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = clear_ptr;
            mem_wdata = '0;
            mem_lanes = '1;
        end else if (wr_accept) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
                if (mem_lanes[i]) begin
                    mem[mem_addr][i*COL_W +: COL_W] <= mem_wdata[i*COL_W +: COL_W];
                end
            end
        end
    end

`ifdef RAM_1W_NRS_CLEARED_BYPASS_EN
    logic [WORD_WIDTH-1:0] fwd_word;
    always_comb begin
        fwd_word = mem[wr_addr];
        for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
            if (wr_mask[i]) begin
                fwd_word[i*COL_W +: COL_W] = wr_data[i*COL_W +: COL_W];
            end
        end
    end
`endif

    logic [WORD_WIDTH-1:0] port_q [READ_PORTS];

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        logic [AW-1:0]         addr;
        logic                  in_range;
        logic                  load;
        logic [WORD_WIDTH-1:0] word;
        logic [WORD_WIDTH-1:0] s1;

        assign addr     = rd_addr[p*AW +: AW];
        assign in_range = ({1'b0, addr} < WC_L);
        assign load     = idle && rd_en[p];

        always_comb begin
            word = '0;
            if (in_range) begin
                word = mem[addr];
`ifdef RAM_1W_NRS_CLEARED_BYPASS_EN
                if (wr_accept && wr_addr == addr) begin
                    word = fwd_word;
                end
`endif
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                s1 <= '0;
            end else if (load) begin
                s1 <= word;
            end
        end

        if (READ_LATENCY == 2) begin : g_lat2
            logic                  s1_vld;
            logic [WORD_WIDTH-1:0] s2;
            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_vld <= 1'b0;
                    s2     <= '0;
                end else begin
                    s1_vld <= load;
                    if (s1_vld) begin
                        s2 <= s1;
                    end
                end
            end
            assign port_q[p] = s2;
        end else begin : g_lat1
            assign port_q[p] = s1;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned p = 0; p < READ_PORTS; p++) begin
            rd_data[p*WORD_WIDTH +: WORD_WIDTH] = port_q[p];
        end
    end

endmodule
